// File: rtl/key_poll_ctrl.sv
// Polls a 4-key PIO over Avalon-MM, debounces each key and queues press/release
// events in a first-word-fall-through FIFO with a sticky overflow flag.
module key_poll_ctrl #(
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        enable,
    output logic [3:0]  key_state,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_data,
    output logic        overflow,
    input  logic        clr_overflow,
    output logic        irq
);
    localparam int TW = $clog2(POLL_DIV);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
    localparam logic [2:0]    CNT_LAST     = 3'(DEBOUNCE_CNT - 1);
    localparam logic [AW:0]   FIFO_FULL    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SCAN} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      key_q, key_d;
    logic [3:0][2:0] cnt_q, cnt_d;
    logic [3:0]      sample_q;
    logic            sample_we;
    logic            push;
    logic [7:0]      push_data;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            pop, full, wr_en, drop;

    logic [3:0]      rd_bits;
    logic            unused_hi;

    assign rd_bits   = ACTIVE_LOW ? ~avm_readdata[3:0] : avm_readdata[3:0];
    assign unused_hi = ^avm_readdata[31:4];

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        sample_we = 1'b0;
        push      = 1'b0;
        push_data = 8'h00;
        avm_read  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    timer_d = TIMER_RELOAD;
                end else if (timer_q == '0) begin
                    state_d = S_REQ;
                    timer_d = TIMER_RELOAD;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            S_REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    // Zero-latency slaves may return data in the accepting cycle.
                    if (avm_readdatavalid) begin
                        sample_we = 1'b1;
                        state_d   = S_SCAN;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (avm_readdatavalid) begin
                    sample_we = 1'b1;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (sample_q[idx_q] == key_q[idx_q]) begin
                    cnt_d[idx_q] = 3'd0;
                end else if (cnt_q[idx_q] == CNT_LAST) begin
                    key_d[idx_q] = ~key_q[idx_q];
                    cnt_d[idx_q] = 3'd0;
                    push         = 1'b1;
                    push_data    = {sample_q[idx_q], 5'b00000, idx_q};
                end else begin
                    cnt_d[idx_q] = cnt_q[idx_q] + 3'd1;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= TIMER_RELOAD;
            idx_q   <= 2'd0;
            key_q   <= 4'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (sample_we) sample_q <= rd_bits;
    end

    // FIFO: a pop frees the slot the same-cycle push lands in, even when full.
    assign pop   = evt_valid & evt_ready;
    assign full  = (count_q == FIFO_FULL);
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (!wr_en && pop) count_d = count_q - (AW + 1)'(1);
        overflow_d = overflow_q;
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign avm_address = 2'b00;
    assign key_state   = key_q;
    assign evt_valid   = (count_q != '0);
    assign evt_data    = evt_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow    = overflow_q;
    assign irq         = evt_valid;

endmodule

// File: tb/tb_key_poll_ctrl.sv
// Scoreboard bench for key_poll_ctrl: an Avalon PIO slave model feeds key
// patterns, expected events are queued and checked by a monitor on pop.
module tb_key_poll_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        enable;
    logic [3:0]  key_state;
    logic        evt_valid;
    logic        evt_ready;
    logic [7:0]  evt_data;
    logic        overflow;
    logic        clr_overflow;
    logic        irq;

    always #5 clk = ~clk;

    key_poll_ctrl #(
        .POLL_DIV(8), .DEBOUNCE_CNT(4), .FIFO_DEPTH(2), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .enable(enable), .key_state(key_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .overflow(overflow), .clr_overflow(clr_overflow), .irq(irq)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // PIO slave: ws_cfg stall cycles, then data lat_cfg cycles after accept.
    logic [3:0] pio;
    int ws_cfg = 0, lat_cfg = 0, ws_cnt = 0, lat_left = 0;
    int rd_run = 0, last_run = 0, acc_cnt = 0;
    int cyc = 0, last_start = -1, period = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'h0;
        forever begin
            @(posedge clk); #1;
            avm_readdatavalid = 1'b0;
            if (reset) begin
                ws_cnt = 0; lat_left = 0; rd_run = 0;
                avm_waitrequest = 1'b0;
            end else begin
                if (lat_left > 0) begin
                    lat_left--;
                    if (lat_left == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = {28'hDEADBEE, pio};
                    end
                end
                if (avm_read) begin
                    if (rd_run == 0) begin
                        if (last_start >= 0) period = cyc - last_start;
                        last_start = cyc;
                    end
                    rd_run++;
                    if (ws_cnt < ws_cfg) begin
                        avm_waitrequest = 1'b1;
                        ws_cnt++;
                    end else begin
                        avm_waitrequest = 1'b0;
                        ws_cnt   = 0;
                        last_run = rd_run;
                        rd_run   = 0;
                        acc_cnt++;
                        check("avm_address", avm_address, 0);
                        if (lat_cfg == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = {28'hDEADBEE, pio};
                        end else begin
                            lat_left = lat_cfg;
                        end
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end
        end
    end

    // Monitor: every pop is compared with the oldest expected event.
    always @(negedge clk) begin
        check("irq_eq_valid", irq, evt_valid);
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_evt: got %0h expected none at %0t", evt_data, $time);
            end else begin
                check("evt_data", evt_data, exp_q.pop_front());
            end
        end
    end

    task automatic polls(input int n);
        int target;
        int budget;
        target = acc_cnt + n;
        budget = 0;
        while (acc_cnt < target && budget < 100 * n) begin
            @(posedge clk);
            budget++;
        end
        if (acc_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL poll_timeout: got %0d expected %0d reads", acc_cnt, target);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avm_read"}, avm_read, 0);
        check({tag, "_avm_address"}, avm_address, 0);
        check({tag, "_key_state"}, key_state, 0);
        check({tag, "_evt_valid"}, evt_valid, 0);
        check({tag, "_evt_data"}, evt_data, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_irq"}, irq, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap;
        int target;
        int budget;
        reset = 1'b0; enable = 1'b0; evt_ready = 1'b0; clr_overflow = 1'b0; pio = 4'hF;
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst0");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        enable = 1'b1;

        // Idle keys: regular polling, no events
        polls(3);
        check("idle_key_state", key_state, 4'h0);
        check("idle_evt_valid", evt_valid, 0);
        check("idle_read_len", last_run, 1);
        check("idle_period", period, 13);

        // Polling stops while disabled
        enable = 1'b0;
        snap = acc_cnt;
        repeat (40) @(posedge clk);
        #1 check("disabled_no_reads", acc_cnt, snap);
        enable = 1'b1;

        // Key 0 press, held until consumer pops
        pio = 4'hE;
        exp_q.push_back(8'h80);
        polls(3);
        check("k0_press_pre", key_state, 4'h0);
        polls(1);
        check("k0_press_state", key_state, 4'h1);
        check("k0_press_valid", evt_valid, 1);
        check("k0_press_data", evt_data, 8'h80);
        check("k0_press_irq", irq, 1);
        evt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("k0_popped", evt_valid, 0);

        // Key 0 release
        pio = 4'hF;
        exp_q.push_back(8'h00);
        polls(3);
        check("k0_rel_pre", key_state, 4'h1);
        polls(1);
        check("k0_rel_state", key_state, 4'h0);

        // Key 2 bounce: three polls low never flips, counter restarts
        pio = 4'hB; polls(3);
        pio = 4'hF; polls(1);
        pio = 4'hB; polls(3);
        check("k2_bounce_state", key_state, 4'h0);
        pio = 4'hF; polls(1);

        // Three presses into a 2-deep FIFO with no consumer
        evt_ready = 1'b0;
        pio = 4'h8;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h81);
        polls(4);
        check("ovf_key_state", key_state, 4'h7);
        check("ovf_flag", overflow, 1);
        check("ovf_head", evt_data, 8'h80);
        @(posedge clk); #1 clr_overflow = 1'b1;
        @(posedge clk); #1 clr_overflow = 1'b0;
        check("ovf_cleared", overflow, 0);
        evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("ovf_drained", evt_valid, 0);

        // Back-to-back releases with a live consumer
        pio = 4'hF;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        polls(4);
        check("rel3_key_state", key_state, 4'h0);
        check("rel3_no_ovf", overflow, 0);

        // Stalled slave with delayed data
        ws_cfg = 5; lat_cfg = 2;
        pio = 4'hE;
        exp_q.push_back(8'h80);
        polls(3);
        check("ws_pre", key_state, 4'h0);
        polls(1);
        check("ws_key_state", key_state, 4'h1);
        check("ws_read_len", last_run, 6);
        check("ws_period", period, 20);
        pio = 4'hF;
        exp_q.push_back(8'h00);
        polls(4);
        check("ws_rel_state", key_state, 4'h0);

        // Reset while waiting for data with a press one poll from flipping
        ws_cfg = 0; lat_cfg = 3;
        pio = 4'hE;
        polls(3);
        target = acc_cnt + 1;
        budget = 0;
        while (acc_cnt < target && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        check("rst_wait_reached", acc_cnt, target);
        #1 reset = 1'b1;
        #1 check_reset_outputs("rst_wait");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        polls(3);
        check("post_rst_state", key_state, 4'h0);
        check("post_rst_valid", evt_valid, 0);
        pio = 4'hF;
        polls(1);

        repeat (5) @(posedge clk);
        #1 check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
